// File: rtl/instr_feeder_if.sv
// Instruction feeder bus: host load port, run control, status, and the
// valid/ready instruction channel toward the core's instruction register.
//   master : the feeder (drives instruction channel and status)
//   slave  : host/core side (drives load port, control and instr_ready)
interface instr_feeder_if #(
    parameter int unsigned ADDR_W = 4
) ();
    // host load port
    logic              load_en;
    logic              load_we;
    logic [15:0]       load_data;
    // run control
    logic              start;
    logic              abort;
    // instruction channel
    logic [31:0]       instr_out;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    // status
    logic [ADDR_W:0]   prog_len;
    logic              busy;
    logic              done;
    logic              load_err;

    modport master (
        input  load_en, load_we, load_data, start, abort, instr_ready,
        output instr_out, instr_pc, instr_valid, prog_len, busy, done, load_err
    );

    modport slave (
        output load_en, load_we, load_data, start, abort, instr_ready,
        input  instr_out, instr_pc, instr_valid, prog_len, busy, done, load_err
    );
endinterface

// File: rtl/instr_feeder.sv
// Program loader and fetch sequencer feeding 32-bit instruction words to the core.
// Load phase: halfword pairs (hi first) from the 16-bit host port fill the
// instruction RAM. Run phase: stored words are issued in order from PC 0 over a
// valid/ready handshake until the program length or a HALT opcode is reached.
// Ports:
//   clock   rising-edge clock
//   reset   asynchronous active-high reset
//   bus     instr_feeder_if.master (load port, start/abort, instruction channel, status)
module instr_feeder #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ADDR_W  = 4,
    parameter logic [4:0]  HALT_OP = 5'h1F
) (
    input  logic               clock,
    input  logic               reset,
    instr_feeder_if.master     bus
);

    localparam int unsigned LEN_W  = ADDR_W + 1;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned HALF_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                half_q, half_d;
    logic [HALF_W-1:0]   hi_q, hi_d;
    logic [LEN_W-1:0]    prog_len_q, prog_len_d;
    logic                load_err_q, load_err_d;
    logic [WORD_W-1:0]   instr_out_q, instr_out_d;
    logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
    logic                instr_valid_q, instr_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                wr_en_c;
    logic [LEN_W-1:0]    nxt_pc_c;
    logic [WORD_W-1:0]   nxt_word_c;
    logic [WORD_W-1:0]   first_word_c;

    // Instruction RAM; contents deliberately survive reset.
    logic [WORD_W-1:0]   mem [DEPTH];

    // RAM write port: completed halfword pair goes to the next free entry.
    always_ff @(posedge clock) begin
        if (wr_en_c) begin
            mem[prog_len_q[ADDR_W-1:0]] <= {hi_q, bus.load_data};
        end
    end

    // Asynchronous-read lookahead of the word after the one being presented.
    assign nxt_pc_c     = LEN_W'(instr_pc_q) + LEN_W'(1);
    assign nxt_word_c   = mem[nxt_pc_c[ADDR_W-1:0]];
    assign first_word_c = mem[0];

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            half_q        <= 1'b0;
            hi_q          <= '0;
            prog_len_q    <= '0;
            load_err_q    <= 1'b0;
            instr_out_q   <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            half_q        <= half_d;
            hi_q          <= hi_d;
            prog_len_q    <= prog_len_d;
            load_err_q    <= load_err_d;
            instr_out_q   <= instr_out_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        half_d        = half_q;
        hi_d          = hi_q;
        prog_len_d    = prog_len_q;
        load_err_d    = load_err_q;
        instr_out_d   = instr_out_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        wr_en_c       = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                instr_valid_d = 1'b0;
                if (bus.load_en) begin
                    // A new session replaces the program.
                    state_d    = S_LOAD;
                    prog_len_d = '0;
                    load_err_d = 1'b0;
                    half_d     = 1'b0;
                end else if (bus.start && (prog_len_q != '0)) begin
                    instr_pc_d = '0;
                    if (first_word_c[31:27] == HALT_OP) begin
                        state_d = S_DONE;
                    end else begin
                        state_d       = S_RUN;
                        instr_out_d   = first_word_c;
                        instr_valid_d = 1'b1;
                    end
                end
            end

            S_LOAD: begin
                if (!bus.load_en) begin
                    // Any unpaired hi halfword is discarded.
                    state_d = S_IDLE;
                    half_d  = 1'b0;
                end else if (bus.load_we) begin
                    if (!half_q) begin
                        hi_d   = bus.load_data;
                        half_d = 1'b1;
                    end else begin
                        half_d = 1'b0;
                        if (prog_len_q == LEN_W'(DEPTH)) begin
                            load_err_d = 1'b1;
                        end else begin
                            wr_en_c    = 1'b1;
                            prog_len_d = prog_len_q + LEN_W'(1);
                        end
                    end
                end
            end

            S_RUN: begin
                if (bus.abort) begin
                    state_d       = S_IDLE;
                    instr_valid_d = 1'b0;
                end else if (instr_valid_q && bus.instr_ready) begin
                    // End of program or HALT: the HALT word is never presented.
                    if ((nxt_pc_c == prog_len_q) || (nxt_word_c[31:27] == HALT_OP)) begin
                        state_d       = S_DONE;
                        instr_valid_d = 1'b0;
                    end else begin
                        instr_out_d = nxt_word_c;
                        instr_pc_d  = nxt_pc_c[ADDR_W-1:0];
                    end
                end
            end

            default: begin
                state_d       = S_IDLE;
                instr_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d == S_LOAD) || (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    assign bus.instr_out   = instr_out_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.prog_len    = prog_len_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.load_err    = load_err_q;

endmodule

// File: tb/tb_instr_feeder.sv
module tb_instr_feeder;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;

    logic clock;
    logic reset;

    int total;
    int bad;

    logic [31:0] prog_q[$];
    logic [35:0] sb_q[$];

    instr_feeder_if #(.ADDR_W(ADDR_W)) bus ();

    instr_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .HALT_OP(5'h1F)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every presented word must match the scoreboard head; pop on accept.
    always @(negedge clock) begin
        if (!reset && bus.instr_valid === 1'b1) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_word: got pc=%0d word=0x%08h expected none",
                         bus.instr_pc, bus.instr_out);
            end else begin
                if ({bus.instr_pc, bus.instr_out} !== sb_q[0]) begin
                    bad++;
                    $display("FAIL issued_word: got pc=%0d word=0x%08h expected pc=%0d word=0x%08h",
                             bus.instr_pc, bus.instr_out, sb_q[0][35:32], sb_q[0][31:0]);
                end
                if (bus.instr_ready) void'(sb_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Loads prog_q as halfword pairs in one session.
    task automatic load_prog();
        bus.load_en = 1'b1;
        cyc();
        foreach (prog_q[i]) begin
            bus.load_we   = 1'b1;
            bus.load_data = prog_q[i][31:16];
            cyc();
            bus.load_data = prog_q[i][15:0];
            cyc();
        end
        bus.load_we = 1'b0;
        bus.load_en = 1'b0;
        cyc();
    endtask

    // Pushes expected issue sequence, starts a run, waits for DONE (bounded).
    task automatic run_prog(input int hold);
        int n;
        int k;
        n = (prog_q.size() > DEPTH) ? DEPTH : prog_q.size();
        for (int i = 0; i < n; i++) begin
            if (prog_q[i][31:27] == 5'h1F) break;
            sb_q.push_back({4'(i), prog_q[i]});
        end
        bus.instr_ready = (hold == 0);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        k = 0;
        while (bus.done !== 1'b1 && k < 200) begin
            if (k >= hold) bus.instr_ready = 1'b1;
            cyc();
            k++;
        end
        check("run_timeout", 32'(k < 200), 32'd1);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        check("done_flag", 32'(bus.done), 32'd1);
        check("valid_after_done", 32'(bus.instr_valid), 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        bus.load_en     = 1'b0;
        bus.load_we     = 1'b0;
        bus.load_data   = '0;
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.instr_ready = 1'b0;
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        cyc();

        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_out", bus.instr_out, 32'h0);
        check("rst_pc", 32'(bus.instr_pc), 32'd0);
        check("rst_len", 32'(bus.prog_len), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.load_err), 32'd0);

        // start with empty program does nothing
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        check("empty_start_busy", 32'(bus.busy), 32'd0);
        check("empty_start_done", 32'(bus.done), 32'd0);

        // single ADDI word
        prog_q = '{32'h10050005};
        load_prog();
        check("t1_len", 32'(bus.prog_len), 32'd1);
        run_prog(0);

        // three words with backpressure on word 0
        prog_q = '{32'h10050005, 32'h09130037, 32'h58000000};
        load_prog();
        check("t2_len", 32'(bus.prog_len), 32'd3);
        run_prog(4);

        // HALT at pc1 stops the run
        prog_q = '{32'h09130037, 32'hF8000000, 32'h10050005};
        load_prog();
        run_prog(0);

        // HALT at pc0: DONE with nothing presented
        prog_q = '{32'hF8000000};
        load_prog();
        run_prog(0);

        // overflow: DEPTH+1 words, last dropped
        prog_q.delete();
        for (int i = 0; i <= DEPTH; i++) prog_q.push_back(32'h08000000 + 32'(i));
        load_prog();
        check("t4_len_sat", 32'(bus.prog_len), 32'(DEPTH));
        check("t4_err", 32'(bus.load_err), 32'd1);
        run_prog(0);
        check("t4_err_kept", 32'(bus.load_err), 32'd1);
        bus.load_en = 1'b1;
        cyc();
        check("t4_new_len", 32'(bus.prog_len), 32'd0);
        check("t4_new_err", 32'(bus.load_err), 32'd0);
        check("t4_busy_load", 32'(bus.busy), 32'd1);
        bus.load_en = 1'b0;
        cyc();

        // one full pair then a dangling hi halfword
        bus.load_en = 1'b1;
        cyc();
        bus.load_we = 1'b1;
        bus.load_data = 16'h2222;
        cyc();
        bus.load_data = 16'h3333;
        cyc();
        bus.load_data = 16'h4444;
        cyc();
        bus.load_we = 1'b0;
        bus.load_en = 1'b0;
        cyc();
        check("t5_len", 32'(bus.prog_len), 32'd1);
        prog_q = '{32'h22223333};
        run_prog(0);
        prog_q = '{32'h10050005};
        load_prog();
        check("t5_len2", 32'(bus.prog_len), 32'd1);
        run_prog(0);

        // abort at pc1 with ready high
        prog_q = '{32'h10050005, 32'h09130037, 32'h58000000};
        load_prog();
        sb_q.push_back({4'd0, 32'h10050005});
        sb_q.push_back({4'd1, 32'h09130037});
        bus.instr_ready = 1'b1;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        check("t6_pc0", 32'(bus.instr_pc), 32'd0);
        cyc();
        check("t6_pc1", 32'(bus.instr_pc), 32'd1);
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        check("t6_valid", 32'(bus.instr_valid), 32'd0);
        check("t6_busy", 32'(bus.busy), 32'd0);
        check("t6_done", 32'(bus.done), 32'd0);
        check("t6_sb", 32'(sb_q.size()), 32'd0);

        // async reset in the middle of a load
        bus.load_en = 1'b1;
        cyc();
        bus.load_we = 1'b1;
        bus.load_data = 16'h5555;
        cyc();
        check("t6_busy_load", 32'(bus.busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_busy", 32'(bus.busy), 32'd0);
        check("ar_len", 32'(bus.prog_len), 32'd0);
        check("ar_out", bus.instr_out, 32'h0);
        check("ar_valid", 32'(bus.instr_valid), 32'd0);
        check("ar_done", 32'(bus.done), 32'd0);
        check("ar_err", 32'(bus.load_err), 32'd0);
        bus.load_we = 1'b0;
        bus.load_en = 1'b0;
        cyc();
        reset = 1'b0;
        cyc();
        check("ar_idle", 32'(bus.busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
